// File: rtl/eb1_ifu_align_pkg.sv
// eb1_ifu_align_pkg: shared state enum, parcel entry and sizing constants for the parcel aligner
package eb1_ifu_align_pkg;
  localparam int PARCEL_W = 16;
  localparam int FETCH_PARCELS = 2;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_RUN  = 2'd2
  } state_t;
  typedef struct packed {
    logic [PARCEL_W-1:0] data;
    logic err;
  } parcel_t;
endpackage

// File: rtl/eb1_ifu_parcel_fifo.sv
// eb1_ifu_parcel_fifo: circular parcel FIFO, push 0/1/2 (push_d0 first) and pop 0/1/2 per cycle; clr empties it; p0/p1 are the two oldest entries, count is occupancy
module eb1_ifu_parcel_fifo
  import eb1_ifu_align_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  input  logic [1:0] push_n,
  input  parcel_t push_d0,
  input  parcel_t push_d1,
  input  logic [1:0] pop_n,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output parcel_t p0,
  output parcel_t p1
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  parcel_t mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, k};
    return s >= (PW+1)'(DEPTH) ? PW'(s - (PW+1)'(DEPTH)) : PW'(s);
  endfunction
  assign p0 = mem[rptr];
  assign p1 = mem[inc(rptr, 2'd1)];
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else if (clr) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push_n != 2'd0) mem[wptr] <= push_d0;
      if (push_n == 2'd2) mem[inc(wptr, 2'd1)] <= push_d1;
      wptr <= inc(wptr, push_n);
      rptr <= inc(rptr, pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end
endmodule

// File: rtl/eb1_ifu_parcel_aligner.sv
// eb1_ifu_parcel_aligner: aligns 32-bit fetch words (fetch_valid/ready, data, err) into 16/32-bit instructions (out_valid/ready, instr, is_c, pc, err), restarting on flush/flush_pc; define RV_ALIGN_EXPAND_EN to expand compressed parcels via eb1_ifu_compress_ctl
module eb1_ifu_parcel_aligner
  import eb1_ifu_align_pkg::*;
#(
  parameter int BUF_PARCELS = 4,
  parameter int PCW = 31
) (
  input  logic clk,
  input  logic rst_l,
  input  logic flush,
  input  logic [PCW-1:0] flush_pc,
  input  logic fetch_valid,
  output logic fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic fetch_err,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_instr,
  output logic out_is_c,
  output logic [PCW-1:0] out_pc,
  output logic out_err
);
  localparam int CW = $clog2(BUF_PARCELS+1);
  state_t state;
  logic [PCW-1:0] head_pc;
  logic [CW-1:0] count;
  parcel_t p0, p1, push_d0, push_d1;
  logic [1:0] push_n, pop_n;
  logic is_c, has, active;
  logic [31:0] c_exp;
  assign active = rst_l & (state != S_IDLE) & !flush;
  assign is_c = p0.data[1:0] != 2'b11;
  assign has = count != '0;
  assign fetch_ready = active & (count <= CW'(BUF_PARCELS-2));
  assign out_valid = active & ((count > CW'(1)) | ((count == CW'(1)) & is_c));
  assign push_n = fetch_valid & fetch_ready ? (state == S_SKIP ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n = out_valid & out_ready ? (is_c ? 2'd1 : 2'd2) : 2'd0;
  assign push_d0 = '{data: state == S_SKIP ? fetch_data[31:16] : fetch_data[15:0], err: fetch_err};
  assign push_d1 = '{data: fetch_data[31:16], err: fetch_err};
`ifdef RV_ALIGN_EXPAND_EN
  eb1_ifu_compress_ctl u_expand (
    .din (p0.data),
    .dout(c_exp)
  );
`else
  assign c_exp = {16'b0, p0.data};
`endif
  assign out_instr = !has ? '0 : is_c ? c_exp : {p1.data, p0.data};
  assign out_is_c = has & is_c;
  assign out_err = has & (is_c ? p0.err : p0.err | p1.err);
  assign out_pc = head_pc;
  eb1_ifu_parcel_fifo #(.DEPTH(BUF_PARCELS)) u_fifo (
    .clk    (clk),
    .rst_l  (rst_l),
    .clr    (flush),
    .push_n (push_n),
    .push_d0(push_d0),
    .push_d1(push_d1),
    .pop_n  (pop_n),
    .count  (count),
    .p0     (p0),
    .p1     (p1)
  );
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state <= S_IDLE;
      head_pc <= '0;
    end else if (flush) begin
      state <= flush_pc[0] ? S_SKIP : S_RUN;
      head_pc <= flush_pc;
    end else begin
      if (state == S_SKIP && push_n != 2'd0) state <= S_RUN;
      if (pop_n != 2'd0) head_pc <= head_pc + (is_c ? PCW'(1) : PCW'(2));
    end
  end
endmodule

// File: tb/tb_eb1_ifu_parcel_aligner.sv
// tb_eb1_ifu_parcel_aligner: randomized and directed checks of the aligner against a parcel-queue reference model
module tb_eb1_ifu_parcel_aligner;
  localparam int BUF = 4;
  logic clk = 0;
  logic rst_l, flush, fetch_valid, fetch_ready, fetch_err, out_valid, out_ready, out_is_c, out_err;
  logic [30:0] flush_pc, out_pc;
  logic [31:0] fetch_data, out_instr;
  int nchk = 0, nerr = 0;
  typedef struct {logic [15:0] d; logic e;} pe_t;
  pe_t q[$];
  int mst = 0;
  logic [30:0] mpc = '0;
  always #5 clk = ~clk;
  eb1_ifu_parcel_aligner #(.BUF_PARCELS(BUF), .PCW(31)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_is_c(out_is_c),
    .out_pc(out_pc), .out_err(out_err)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic f, input logic [30:0] fp, input logic fv,
                     input logic [31:0] fd, input logic fe, input logic ordy);
    logic efr, eov, ec;
    @(negedge clk);
    rst_l = r; flush = f; flush_pc = fp; fetch_valid = fv; fetch_data = fd; fetch_err = fe; out_ready = ordy;
    #1;
    ec = q.size() > 0 && q[0].d[1:0] != 2'b11;
    efr = r && mst != 0 && !f && q.size() <= BUF - 2;
    eov = r && mst != 0 && !f && (q.size() >= 2 || (q.size() == 1 && ec));
    chk("fetch_ready", 64'(fetch_ready), 64'(efr));
    chk("out_valid", 64'(out_valid), 64'(eov));
    if (r) chk("out_pc", 64'(out_pc), 64'(mpc));
    if (eov) begin
      chk("out_is_c", 64'(out_is_c), 64'(ec));
      chk("out_instr", 64'(out_instr), ec ? 64'(q[0].d) : 64'({q[1].d, q[0].d}));
      chk("out_err", 64'(out_err), ec ? 64'(q[0].e) : 64'(q[0].e | q[1].e));
    end
    if (!r) begin
      q.delete(); mst = 0; mpc = '0;
    end else if (f) begin
      q.delete(); mpc = fp; mst = fp[0] ? 1 : 2;
    end else begin
      if (eov && ordy) begin
        void'(q.pop_front());
        if (!ec) void'(q.pop_front());
        mpc = mpc + (ec ? 31'd1 : 31'd2);
      end
      if (efr && fv) begin
        if (mst == 2) q.push_back('{fd[15:0], fe});
        q.push_back('{fd[31:16], fe});
        mst = 2;
      end
    end
  endtask
  task automatic idle(input logic ordy);
    cyc(1, 0, '0, 0, '0, 0, ordy);
  endtask
  task automatic push(input logic [31:0] w, input logic e, input logic ordy);
    cyc(1, 0, '0, 1, w, e, ordy);
  endtask
  task automatic fl(input logic [30:0] p);
    cyc(1, 1, p, 0, '0, 0, 0);
  endtask
  initial begin
    cyc(0, 0, '0, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 32'h1234_5678, 1, 1);
    chk("rst_instr", 64'(out_instr), 0);
    chk("rst_is_c", 64'(out_is_c), 0);
    chk("rst_err", 64'(out_err), 0);
    idle(1);
    chk("idle_ready", 64'(fetch_ready), 0);
    fl(31'h0);
    push(32'h0001_4501, 0, 0);
    idle(1);
    chk("t1_a", {out_valid, out_is_c, out_pc, out_instr}, {1'b1, 1'b1, 31'h0, 32'h0000_4501});
    idle(1);
    chk("t1_b", {out_valid, out_is_c, out_pc, out_instr}, {1'b1, 1'b1, 31'h1, 32'h0000_0001});
    fl(31'h0);
    push(32'h0513_4501, 0, 1);
    idle(1);
    push(32'h0000_0000, 0, 1);
    chk("t2_hold", 64'(out_valid), 0);
    idle(1);
    chk("t2_str", {out_valid, out_is_c, out_pc, out_instr}, {1'b1, 1'b0, 31'h1, 32'h0000_0513});
    fl(31'h81);
    push(32'h4505_FFFF, 0, 1);
    idle(1);
    chk("t3_skip", {out_valid, out_is_c, out_pc, out_instr}, {1'b1, 1'b1, 31'h81, 32'h0000_4505});
    fl(31'h0);
    push(32'h0513_4501, 0, 0);
    push(32'h0001_0000, 1, 0);
    idle(1);
    chk("t5_c_err", {out_valid, out_is_c, out_err}, {1'b1, 1'b1, 1'b0});
    idle(1);
    chk("t5_32_err", {out_valid, out_is_c, out_err, out_instr}, {1'b1, 1'b0, 1'b1, 32'h0000_0513});
    fl(31'h81);
    push(32'h0001_4501, 0, 0);
    push(32'h0002_0003, 0, 0);
    chk("t6_cnt3", 64'(q.size()), 3);
    cyc(1, 1, 31'h40, 1, 32'hAAAA_5555, 0, 1);
    chk("t6_noout", {out_valid, fetch_ready}, 0);
    idle(1);
    chk("t6_after", {out_valid, out_pc}, {1'b0, 31'h40});
    fl(31'h10);
    for (int i = 0; i < 6; i++) push($urandom, 0, 0);
    chk("t4_full", 64'(fetch_ready), 0);
    for (int i = 0; i < 3000; i++) begin
      int x;
      x = $urandom_range(0, 999);
      if (x < 3) cyc(0, 0, '0, 0, '0, 0, 0);
      else if (x < 25) cyc(1, 1, $urandom_range(0, 3) != 0 ? 31'($urandom) : 31'h7fff_fffe, 0, '0, 0, 0);
      else cyc(1, 0, '0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      if (mst == 0) fl(31'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
